// File: rtl/progmem_loader.sv
// Framed byte-stream loader for the instruction store; holds the core until an image is loaded.
// Define LOADER_CSUM_EN to require a trailing XOR checksum byte after the data.
module progmem_loader #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [31:0] address,
  output logic [31:0] instruction,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err
);

  localparam logic [7:0]  SyncByte = 8'hA5;
  localparam logic [15:0] DepthW   = 16'(DEPTH);
  localparam logic [31:0] BadInstr = 32'hFC00_0000;

  typedef enum logic [2:0] {
    StSync  = 3'd0,
    StCntHi = 3'd1,
    StCntLo = 3'd2,
    StData  = 3'd3,
`ifdef LOADER_CSUM_EN
    StCsum  = 3'd4,
`endif
    StDone  = 3'd5,
    StErr   = 3'd6
  } state_e;

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [AW:0] wp_q;
  logic [1:0]  byte_idx_q;
  logic [23:0] shift_q;
  logic        load_done_q;
  logic        load_err_q;
  logic        rx_ready_q;
`ifdef LOADER_CSUM_EN
  logic [7:0]  csum_q;
`endif

  logic [31:0] mem [DEPTH];

  logic        accept;
  logic        mem_we;
  logic        last_word;
  logic [15:0] count_rx;
  logic [31:0] word;

  always_comb begin
    accept    = rx_valid & rx_ready_q;
    mem_we    = accept && (state_q == StData) && (byte_idx_q == 2'd3);
    last_word = (16'(wp_q) == (cnt_q - 16'd1));
    count_rx  = {cnt_q[15:8], rx_data};
    word      = {shift_q, rx_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StSync;
      cnt_q       <= '0;
      wp_q        <= '0;
      byte_idx_q  <= '0;
      shift_q     <= '0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      rx_ready_q  <= 1'b1;
`ifdef LOADER_CSUM_EN
      csum_q      <= '0;
`endif
    end else if (accept) begin
      unique case (state_q)
        StSync: begin
          if (rx_data == SyncByte) state_q <= StCntHi;
        end
        StCntHi: begin
          cnt_q   <= {rx_data, 8'h00};
          state_q <= StCntLo;
        end
        StCntLo: begin
          cnt_q[7:0] <= rx_data;
          if ((count_rx == 16'd0) || (count_rx > DepthW)) begin
            load_err_q <= 1'b1;
            state_q    <= StErr;
          end else begin
            wp_q       <= '0;
            byte_idx_q <= '0;
`ifdef LOADER_CSUM_EN
            csum_q     <= '0;
`endif
            state_q    <= StData;
          end
        end
        StData: begin
          shift_q    <= {shift_q[15:0], rx_data};
          byte_idx_q <= byte_idx_q + 2'd1;
`ifdef LOADER_CSUM_EN
          csum_q     <= csum_q ^ rx_data;
`endif
          if (byte_idx_q == 2'd3) begin
            wp_q <= wp_q + 1'b1;
            if (last_word) begin
`ifdef LOADER_CSUM_EN
              state_q <= StCsum;
`else
              load_done_q <= 1'b1;
              rx_ready_q  <= 1'b0;
              state_q     <= StDone;
`endif
            end
          end
        end
`ifdef LOADER_CSUM_EN
        StCsum: begin
          if (rx_data == csum_q) begin
            load_done_q <= 1'b1;
            rx_ready_q  <= 1'b0;
            state_q     <= StDone;
          end else begin
            load_err_q <= 1'b1;
            state_q    <= StErr;
          end
        end
`endif
        StDone: begin
          state_q <= StDone;
        end
        StErr: begin
          // Only a fresh sync byte restarts the load; everything else is dropped.
          if (rx_data == SyncByte) begin
            load_err_q <= 1'b0;
            state_q    <= StCntHi;
          end
        end
        default: state_q <= StSync;
      endcase
    end
  end

  // Store is deliberately not reset so a partial image survives a mid-load reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wp_q[AW-1:0]] <= word;
  end

  always_comb begin
    instruction = BadInstr;
    if (address < 32'(DEPTH)) instruction = mem[address[AW-1:0]];
  end

  assign rx_ready  = rx_ready_q;
  assign load_done = load_done_q;
  assign load_err  = load_err_q;
  assign cpu_hold  = ~load_done_q;

endmodule

// File: tb/tb_progmem_loader.sv
// Randomized bench for progmem_loader against a frame-level store model.
module tb_progmem_loader;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [31:0] address = 32'h0;
  logic [31:0] instruction;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  progmem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .address     (address),
    .instruction (instruction),
    .cpu_hold    (cpu_hold),
    .load_done   (load_done),
    .load_err    (load_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int gap_mode = 0;

  // Reference store: what each address should hold, and whether it was ever written.
  logic [31:0] exp_mem [DEPTH];
  bit          exp_vld [DEPTH];
  logic [31:0] frame_w [DEPTH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int gap;
    int t;
    gap = (gap_mode == 1) ? 1 : int'($urandom_range(0, 2));
    t = 0;
    @(negedge clk);
    repeat (gap) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && t < 64) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) begin
      check("ready_timeout", 32'(rx_ready), 32'd1);
      rx_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_flags(input string tag, input bit done, input bit err);
    check({tag, "_done"}, 32'(load_done), 32'(done));
    check({tag, "_err"}, 32'(load_err), 32'(err));
    check({tag, "_hold"}, 32'(cpu_hold), 32'(!done));
    check({tag, "_ready"}, 32'(rx_ready), 32'(!done));
  endtask

  task automatic read_word(input int a, input logic [31:0] exp);
    address = 32'(a);
    #1;
    check($sformatf("fetch_%0d", a), instruction, exp);
  endtask

  // Sends a well-formed frame of n words from frame_w; probe checks same-edge read semantics.
  task automatic load_frame(input int n, input bit probe);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'h00;
    send_byte(8'hA5);
    send_byte(8'(n >> 8));
    send_byte(8'(n));
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 4; j++) begin
        b  = frame_w[i][31-8*j -: 8];
        cs = cs ^ b;
        if (j == 3 && probe && exp_vld[i]) read_word(i, exp_mem[i]);
        if (j == 3 && i == n - 1) check("hold_before_last", 32'(cpu_hold), 32'd1);
        send_byte(b);
        if (j == 3) begin
          exp_mem[i] = frame_w[i];
          exp_vld[i] = 1'b1;
          if (probe) begin
            address = 32'(i);
            #1;
            check("new_word", instruction, frame_w[i]);
          end
        end
      end
    end
`ifdef LOADER_CSUM_EN
    send_byte(cs);
`endif
    check_flags("frame_end", 1'b1, 1'b0);
  endtask

  task automatic check_oor();
    logic [31:0] a;
    a = $urandom;
    if (a < DEPTH) a = a + DEPTH;
    address = a;
    #1;
    check("oor_fetch", instruction, 32'hFC00_0000);
  endtask

  initial begin
    int n;
    for (int i = 0; i < DEPTH; i++) exp_vld[i] = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check_flags("reset", 1'b0, 1'b0);
    rst_n = 1'b1;

    // Single-word load
    frame_w[0] = 32'h8C01_0004;
    load_frame(1, 1'b0);
    read_word(0, 32'h8C01_0004);
    read_word(300, 32'hFC00_0000);
    read_word(256, 32'hFC00_0000);

    // Garbage, zero count, then restart from ERR
    do_reset();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    check_flags("zero_cnt", 1'b0, 1'b1);
    frame_w[0] = 32'h0000_002A;
    load_frame(1, 1'b0);
    read_word(0, 32'h0000_002A);

    // Count overflow: N = 257 must error with no writes
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h01);
    check_flags("overflow", 1'b0, 1'b1);
    read_word(0, exp_mem[0]);

    // Throttled 3-word load, then DONE back-pressure
    do_reset();
    gap_mode = 1;
    for (int i = 0; i < 3; i++) frame_w[i] = $urandom;
    load_frame(3, 1'b1);
    gap_mode = 0;
    @(negedge clk);
    rx_data  = 8'hA5;
    rx_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("bp_ready", 32'(rx_ready), 32'd0);
      rx_data = 8'($urandom);
    end
    rx_valid = 1'b0;
    check_flags("after_bp", 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) read_word(i, exp_mem[i]);

    // Reset mid-load after 2 of 4 words
    do_reset();
    for (int i = 0; i < 4; i++) frame_w[i] = $urandom;
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h04);
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 4; j++) send_byte(frame_w[i][31-8*j -: 8]);
      exp_mem[i] = frame_w[i];
      exp_vld[i] = 1'b1;
    end
    send_byte(frame_w[2][31:24]);
    #2;
    rst_n = 1'b0;
    #1;
    check_flags("mid_reset", 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    read_word(0, exp_mem[0]);
    read_word(1, exp_mem[1]);

    // Randomized loads over a store that already holds older words
    for (int it = 0; it < 6; it++) begin
      do_reset();
      gap_mode = int'($urandom_range(0, 1));
      if (it == 1) begin
        send_byte(8'h3C);
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h00);
        check("rand_err", 32'(load_err), 32'd1);
      end
      n = (it == 0) ? DEPTH : int'($urandom_range(1, 40));
      for (int i = 0; i < n; i++) frame_w[i] = $urandom;
      load_frame(n, 1'b1);
      for (int i = 0; i < n; i += (n > 40) ? 17 : 1) read_word(i, exp_mem[i]);
      check_oor();
    end
    gap_mode = 0;

`ifdef LOADER_CSUM_EN
    do_reset();
    frame_w[0] = 32'h1234_5678;
    load_frame(1, 1'b0);
    read_word(0, 32'h1234_5678);
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h78);
    send_byte(8'h09);
    check_flags("bad_csum", 1'b0, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/progmem_loader.md
# progmem_loader

Writer side of the instruction-fetch interface. Receives a framed byte stream over a valid/ready link and assembles big-endian 32-bit words into an internal instruction store. Serves the datapath's combinational fetch port from that store. Holds the core in halt until a complete, valid image is loaded, which replaces hard-coded program-memory initialisation.

## Interface
**Parameters**
- `DEPTH`, 256: instruction store depth in 32-bit words.
- `AW`, 8: word-address width, `$clog2(DEPTH)`.

**Ports**
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `rx_data`  in  8: stream byte.
- `rx_valid`  in  1: `rx_data` is valid.
- `rx_ready`  out  1: loader accepts a byte this cycle.
- `address`  in  32: fetch word address from the PC.
- `instruction`  out  32: fetched word (combinational).
- `cpu_hold`  out  1: high until a load completes successfully.
- `load_done`  out  1: image loaded; sticky until reset or restart.
- `load_err`  out  1: frame error; sticky until reset or restart.

## Operation
- **Frame format:** `0xA5` sync, then N_hi, N_lo (N = word count), then 4·N data bytes with MSB first per word. With `LOADER_CSUM_EN`, one checksum byte follows the data.
- **Byte acceptance:** a byte is accepted when `rx_valid & rx_ready` is high at a rising `clk`.
- **FSM states:** SYNC, CNT_HI, CNT_LO, DATA, CSUM, DONE, ERR.
  - **SYNC:** `0xA5` goes to CNT_HI. Any other byte is discarded and the FSM stays in SYNC.
  - **CNT_HI:** latch N[15:8], go to CNT_LO.
  - **CNT_LO:** latch N[7:0]. If N == 0 or N > DEPTH, go to ERR. Otherwise clear the word pointer (wp = 0) and byte index, then go to DATA.
  - **DATA:** shift the byte into the word assembler. On the 4th byte, write `mem[wp]` with the assembled word on the same edge, then increment wp. After word N-1 is written, go to CSUM if `LOADER_CSUM_EN`, else go to DONE.
  - **CSUM:** compare against the running XOR of all data bytes. Match goes to DONE; mismatch goes to ERR.
  - **DONE:** `rx_ready` = 0. The store is frozen.
  - **ERR:** `rx_ready` = 1. A byte `0xA5` restarts the load: clear `load_err`, go to CNT_HI. Other bytes are discarded.
- **Ready signal:** `rx_ready` = 1 in every state except DONE.
- **Fetch port:**
  - `instruction = mem[address[AW-1:0]]` when `address < DEPTH`.
  - Otherwise `instruction = 32'hFC00_0000` (invalid opcode 6'h3F).
  - Store words not yet written read as X. The datapath must not fetch while `cpu_hold` = 1.
- **Hold signal:** `cpu_hold = ~load_done`.
- **Width rules:**
  - N is 16 bits, compared unsigned against DEPTH.
  - wp is AW+1 bits. wp never exceeds N ≤ DEPTH, so it does not wrap.
  - The checksum is an 8-bit XOR.

## Timing
- **Reset values:**
  - `rx_ready` = 1, `cpu_hold` = 1, `load_done` = 0, `load_err` = 0.
  - FSM = SYNC, wp = 0, byte index = 0, checksum = 0.
  - Store contents are not cleared.
- **Reset mid-load:** reset takes effect immediately (asynchronous) and returns to SYNC. Words already written remain in the store.
- **Write latency:** `mem[wp]` is readable on `instruction` in the cycle after the edge that accepted the word's 4th byte.
- **Done/error latency:** `load_done` or `load_err` rises on the edge that accepts the final byte (last data byte or checksum byte). `cpu_hold` falls on that same edge.
- **Stalls:** `rx_valid` low stalls the FSM with no timeout. Gaps between bytes are arbitrary.
- **Simultaneous events:** a fetch to an address written on the same edge returns the old word in that cycle and the new word in the next cycle.

## Configuration
- `LOADER_CSUM_EN` **defined:**
  - The CSUM state exists and a trailing checksum byte is required.
  - The checksum is the XOR of all 4·N data bytes, seeded with 0.
  - A mismatch gives `load_err` = 1 and `load_done` = 0.
- `LOADER_CSUM_EN` **undefined:**
  - The CSUM state and the XOR register are removed.
  - DONE is entered directly after the last data byte.

## Test plan
- **Single-word load (no csum):** after reset, send `A5 00 01 8C 01 00 04`. Required: `load_done` = 1 and `cpu_hold` = 0 on the edge accepting `04`. `address` = 0 then gives `instruction` = `32'h8C01_0004`, and `address` = 300 gives `32'hFC00_0000`.
- **Garbage then zero count:** send `00 FF A5 00 00`. Required: `load_err` = 1 after the 5th byte, `load_done` = 0. Then sending `A5 00 01 00 00 00 2A` gives `load_err` = 0, `load_done` = 1, and `mem[0]` = `32'h0000_002A`.
- **Count overflow:** send `A5 01 01` (N = 257) with DEPTH = 256. Required: `load_err` = 1 after the 3rd byte, no store writes.
- **Throttled stream and DONE back-pressure:** load 3 words with `rx_valid` toggling every other cycle. Required: all 3 words match the stream. After DONE, `rx_ready` = 0 and extra bytes are ignored.
- **Reset mid-load:** assert `rst_n` low after 2 of 4 words. Required: immediately `rx_ready` = 1, `load_done` = 0, `cpu_hold` = 1. Words 0–1 still read back.
- **Checksum (`LOADER_CSUM_EN`):** send `A5 00 01 12 34 56 78 08`. Required: `load_done` = 1. Sending checksum byte `09` instead gives `load_err` = 1 and `cpu_hold` stays 1.
